// File: rtl/quad_motion_pkg.sv
// quad_motion_pkg: command/status codes and sequencer states for quad_motion_ctrl
package quad_motion_pkg;
    localparam logic [1:0] OP_HOME    = 2'd0;
    localparam logic [1:0] OP_MOVE    = 2'd1;
    localparam logic [1:0] OP_ZERO    = 2'd2;
    localparam logic [1:0] OP_CLRERR  = 2'd3;
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_ENC_ERR = 2'd2;
    localparam logic [1:0] ST_REJECT  = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE, S_HOME_SEEK, S_MOVE, S_SETTLE, S_CLR, S_BLANK, S_FAULT
    } state_t;
endpackage

// File: rtl/quad_stall_timer.sv
// quad_stall_timer: counts enabled cycles, one-cycle expire on cycle TC-1 after clear/enable
module quad_stall_timer #(
    parameter int TC = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else cnt <= (clr || !en) ? '0 : cnt + 1'b1;
    end
    assign expire = en && !clr && cnt == CW'(TC - 1);
endmodule

// File: rtl/quad_motion_ctrl.sv
// quad_motion_ctrl: command-driven motion sequencer over a quadrature decoder
module quad_motion_ctrl
    import quad_motion_pkg::*;
#(
    parameter int POS_W      = 16,
    parameter int STALL_CYC  = 1024,
    parameter int SETTLE_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic signed [POS_W-1:0] cmd_target,
    input  logic                    enc_inc,
    input  logic                    enc_dec,
    input  logic                    enc_err,
    input  logic                    index,
    output logic                    dec_clear,
    output logic                    motor_en,
    output logic                    motor_dir,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status
);
    state_t state, state_nxt;
    logic signed [POS_W-1:0] target_q, tgt_nxt, pos_step;
    logic rdy_q, idx_q, zero, accept, err_go, stall_exp, settle_exp;
    logic dir_nxt, done_nxt, dec_clear_nxt;
    logic [1:0] status_nxt;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = rdy_q && (state == S_IDLE || state == S_FAULT);
    assign busy      = state inside {S_HOME_SEEK, S_MOVE, S_SETTLE, S_CLR, S_BLANK};
    assign pos_step  = (enc_inc && !enc_dec) ? position + 1'b1 :
                       (enc_dec && !enc_inc) ? position - 1'b1 : position;
    assign err_go    = enc_err && !(state inside {S_CLR, S_BLANK, S_FAULT}) &&
                       !(accept && cmd_op == OP_CLRERR);

    quad_stall_timer #(.TC(STALL_CYC)) u_stall (
        .clk, .reset_n, .clr(enc_inc | enc_dec),
        .en(state == S_HOME_SEEK || state == S_MOVE), .expire(stall_exp)
    );
    quad_stall_timer #(.TC(SETTLE_CYC)) u_settle (
        .clk, .reset_n, .clr(1'b0), .en(state == S_SETTLE), .expire(settle_exp)
    );

    always_comb begin
        state_nxt     = state;
        tgt_nxt       = target_q;
        dir_nxt       = motor_dir;
        done_nxt      = 1'b0;
        status_nxt    = ST_OK;
        dec_clear_nxt = 1'b0;
        zero          = 1'b0;
        unique case (state)
            S_IDLE: if (accept) begin
                if (cmd_op == OP_CLRERR) begin
                    state_nxt     = S_CLR;
                    dec_clear_nxt = 1'b1;
                end else if (cmd_op == OP_HOME) begin
                    state_nxt = S_HOME_SEEK;
                    dir_nxt   = 1'b0;
                end else if (cmd_op == OP_ZERO) begin
                    zero     = 1'b1;
                    done_nxt = 1'b1;
                end else if (cmd_target == position) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = S_MOVE;
                    tgt_nxt   = cmd_target;
                    dir_nxt   = cmd_target > position;
                end
            end
            S_HOME_SEEK: if (index && !idx_q) begin
                zero      = 1'b1;
                state_nxt = S_SETTLE;
            end else if (stall_exp) begin
                state_nxt  = S_FAULT;
                done_nxt   = 1'b1;
                status_nxt = ST_STALL;
            end
            S_MOVE: if (pos_step == target_q) begin
                state_nxt = S_SETTLE;
            end else if (stall_exp) begin
                state_nxt  = S_FAULT;
                done_nxt   = 1'b1;
                status_nxt = ST_STALL;
            end
            S_SETTLE: if (settle_exp) begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            S_CLR: state_nxt = S_BLANK;
            S_BLANK: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            S_FAULT: if (accept) begin
                if (cmd_op == OP_CLRERR) begin
                    state_nxt     = S_CLR;
                    dec_clear_nxt = 1'b1;
                end else begin
                    done_nxt   = 1'b1;
                    status_nxt = ST_REJECT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Decoder error outranks every same-cycle outcome, including home capture
        if (err_go) begin
            state_nxt  = S_FAULT;
            done_nxt   = 1'b1;
            status_nxt = ST_ENC_ERR;
            zero       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            position  <= '0;
            target_q  <= '0;
            motor_en  <= 1'b0;
            motor_dir <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
            dec_clear <= 1'b0;
            idx_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            position  <= zero ? '0 : pos_step;
            target_q  <= tgt_nxt;
            motor_en  <= state_nxt == S_HOME_SEEK || state_nxt == S_MOVE;
            motor_dir <= dir_nxt;
            done      <= done_nxt;
            status    <= status_nxt;
            dec_clear <= dec_clear_nxt;
            idx_q     <= index;
            rdy_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_quad_motion_ctrl.sv
// tb_quad_motion_ctrl: directed sequence with a status scoreboard for quad_motion_ctrl
module tb_quad_motion_ctrl;
    import quad_motion_pkg::*;
    localparam int STALL  = 32;
    localparam int SETTLE = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [15:0] cmd_target = 16'd0;
    logic enc_inc = 1'b0, enc_dec = 1'b0, enc_err = 1'b0, index = 1'b0;
    logic dec_clear, motor_en, motor_dir, busy, done;
    logic [15:0] position;
    logic [1:0] status;
    int n_chk = 0, n_fail = 0;
    logic [1:0] sb[$];

    quad_motion_ctrl #(.POS_W(16), .STALL_CYC(STALL), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_target(cmd_target), .enc_inc(enc_inc), .enc_dec(enc_dec),
        .enc_err(enc_err), .index(index), .dec_clear(dec_clear), .motor_en(motor_en),
        .motor_dir(motor_dir), .position(position), .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] tgt, input logic [1:0] st);
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt;
        sb.push_back(st);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse(input logic inc, input logic dec);
        enc_inc = inc; enc_dec = dec;
        tick();
        enc_inc = 1'b0; enc_dec = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Every done pulse must match the oldest outstanding command
    always @(negedge clk) if (reset_n && done) begin
        chk("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("status", 32'(status), 32'(sb.pop_front()));
    end

    initial begin
        int cnt;
        repeat (3) tick();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_men", 32'(motor_en), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        send(OP_MOVE, 16'd5, ST_OK);
        chk("mv5_men", 32'(motor_en), 32'd1);
        chk("mv5_dir", 32'(motor_dir), 32'd1);
        chk("mv5_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) tick();
            pulse(1'b1, 1'b0);
            chk("mv5_men_run", 32'(motor_en), 32'(i < 4));
        end
        chk("mv5_pos", 32'(position), 32'd5);
        repeat (SETTLE - 1) tick();
        chk("settle_early", 32'(done), 32'd0);
        tick();
        chk("settle_done", 32'(done), 32'd1);
        drain("mv5_drain");

        send(OP_MOVE, 16'hFFFD, ST_OK);
        chk("mvn3_dir", 32'(motor_dir), 32'd0);
        chk("mvn3_men", 32'(motor_en), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0, 1'b1);
            tick();
        end
        chk("mvn3_pos", 32'(position), 32'h0000FFFD);
        drain("mvn3_drain");
        send(OP_MOVE, 16'hFFFD, ST_OK);
        chk("same_men", 32'(motor_en), 32'd0);
        chk("same_done", 32'(done), 32'd1);
        tick();
        chk("same_men2", 32'(motor_en), 32'd0);
        drain("same_drain");

        send(OP_HOME, 16'd0, ST_OK);
        chk("home_men", 32'(motor_en), 32'd1);
        chk("home_dir", 32'(motor_dir), 32'd0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1);
            tick();
        end
        chk("home_pos", 32'(position), 32'h0000FFFA);
        index = 1'b1;
        pulse(1'b0, 1'b1);
        chk("home_zero", 32'(position), 32'd0);
        chk("home_men_off", 32'(motor_en), 32'd0);
        tick();
        index = 1'b0;
        drain("home_drain");
        chk("home_pos_end", 32'(position), 32'd0);

        send(OP_MOVE, 16'd100, ST_STALL);
        cnt = 0;
        for (int i = 0; i < 200 && motor_en; i++) begin
            cnt++;
            tick();
        end
        chk("stall_len", 32'(cnt), 32'(STALL));
        chk("fault_ready", 32'(cmd_ready), 32'd1);
        chk("fault_busy", 32'(busy), 32'd0);
        drain("stall_drain");
        send(OP_MOVE, 16'd7, ST_REJECT);
        chk("reject_men", 32'(motor_en), 32'd0);
        drain("reject_drain");
        send(OP_CLRERR, 16'd0, ST_OK);
        chk("clr_pulse", 32'(dec_clear), 32'd1);
        drain("clr_drain");

        send(OP_MOVE, 16'd1, ST_ENC_ERR);
        enc_err = 1'b1;
        pulse(1'b1, 1'b0);
        chk("err_men", 32'(motor_en), 32'd0);
        chk("err_pos", 32'(position), 32'd1);
        repeat (5) tick();
        enc_err = 1'b0;
        drain("err_drain");
        send(OP_CLRERR, 16'd0, ST_OK);
        chk("clr2_pulse", 32'(dec_clear), 32'd1);
        tick();
        chk("clr2_pulse_once", 32'(dec_clear), 32'd0);
        drain("clr2_drain");
        chk("clr2_idle_busy", 32'(busy), 32'd0);
        send(OP_MOVE, 16'd1, ST_OK);
        drain("idle_move_drain");

        pulse(1'b1, 1'b1);
        chk("both_pos", 32'(position), 32'd1);
        enc_inc = 1'b1;
        send(OP_ZERO, 16'd0, ST_OK);
        enc_inc = 1'b0;
        chk("zero_pos", 32'(position), 32'd0);
        drain("zero_drain");
        enc_inc = 1'b1;
        repeat (32767) tick();
        enc_inc = 1'b0;
        chk("pos_max", 32'(position), 32'h00007FFF);
        pulse(1'b1, 1'b0);
        chk("pos_wrap", 32'(position), 32'h00008000);

        send(OP_MOVE, 16'd0, ST_OK);
        chk("rmv_dir", 32'(motor_dir), 32'd1);
        repeat (3) tick();
        chk("rmv_men", 32'(motor_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_men", 32'(motor_en), 32'd0);
        chk("async_pos", 32'(position), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rerelease_ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/quad_motion_ctrl.md
Name: quad_motion_ctrl

Overview:
Command-driven motion sequencer that sits on top of a quadrature decoder and owns the motor enable and direction lines. It tracks absolute position from the decoder's per-edge inc/dec pulses. It executes HOME, MOVE, ZERO and CLRERR commands over a valid/ready handshake. It also detects encoder stall and decoder error, reporting completion with a status code.

Parameters:
POS_W, 16, width of signed position and target
STALL_CYC, 1024, cycles without an encoder edge while driving before a stall fault (>=2)
SETTLE_CYC, 16, cycles motor held off after reaching the goal before completion (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=HOME 1=MOVE 2=ZERO 3=CLRERR
cmd_target  in  POS_W  signed MOVE target (ignored otherwise)
enc_inc  in  1  one-cycle pulse, decoder counted up
enc_dec  in  1  one-cycle pulse, decoder counted down
enc_err  in  1  decoder illegal-transition level
index  in  1  encoder index, synchronous to clk
dec_clear  out  1  one-cycle pulse that clears decoder error state
motor_en  out  1  drive motor
motor_dir  out  1  1=positive direction
position  out  POS_W  signed current position
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
status  out  2  valid with done: 0=OK 1=STALL 2=ENC_ERR 3=REJECT

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. State IDLE; position 0; motor_en, motor_dir, busy, done, dec_clear, status all 0. cmd_ready is 1 from the first clock after reset release. Reset mid-move stops the motor immediately.
- States: IDLE, HOME_SEEK, MOVE, SETTLE, CLR, FAULT.
- cmd_ready = 1 in IDLE and FAULT only. busy = 1 in HOME_SEEK, MOVE, SETTLE, CLR.
- Position register: +1 on enc_inc, -1 on enc_dec, unchanged if both or neither. Wraps modulo 2^POS_W. Updates in every state. ZERO and the home capture override any same-cycle pulse.
- IDLE, HOME accepted: next cycle HOME_SEEK, motor_en=1, motor_dir=0. A rising edge of index (registered previous value 0, current 1) captures position=0, drops motor_en the same cycle, and moves to SETTLE.
- IDLE, MOVE accepted: if cmd_target==position, done/OK next cycle and no motor activity. Otherwise latch the target and go to MOVE. motor_dir = (target > position) as a signed compare, fixed at accept. motor_en=1. When position==target, motor_en drops the same cycle and the state moves to SETTLE. Overshoot during SETTLE is not corrected.
- SETTLE: motor_en=0 for SETTLE_CYC cycles, then done=1 with status OK, then IDLE.
- IDLE, ZERO accepted: position=0 next cycle, done/OK the same cycle.
- CLRERR accepted (IDLE or FAULT): CLR state for one cycle with dec_clear=1, then one blanking cycle ignoring enc_err. Then done/OK, then IDLE.
- Stall: a counter clears on state entry and on any enc_inc/enc_dec. If it reaches STALL_CYC-1 in HOME_SEEK or MOVE, go to FAULT with done/STALL.
- enc_err=1 in any state except CLR/blanking: go to FAULT with motor_en=0 the next cycle and done/ENC_ERR (done once only). enc_err has priority over stall and over target/index reached in the same cycle.
- FAULT: motor off; only CLRERR is serviced. HOME/MOVE/ZERO are accepted and produce done/REJECT next cycle, remaining in FAULT.
- Exactly one done pulse per accepted command.

Decomposition:
- Package quad_motion_pkg: op-code constants, status-code constants, state enumeration.
- One sub-module, quad_stall_timer: clear/enable inputs, parameterised terminal count, one-cycle expire output. Reused for the SETTLE count by loading SETTLE_CYC.

Test Plan:
- Reset release, MOVE target=5, drive 5 enc_inc pulses -> motor_en=1 dir=1 until position=5. SETTLE_CYC cycles later, done/OK. position=5.
- From position 5, MOVE target=-3 with 8 enc_dec pulses -> dir=0, position=0xFFFD, done/OK. MOVE target=-3 again -> done/OK next cycle, motor_en never asserts.
- HOME with 3 enc_dec pulses then an index rising edge coincident with an enc_dec -> position=0 (pulse ignored), done/OK.
- MOVE target=100 with no encoder pulses -> after STALL_CYC cycles motor_en=0, done/STALL, state FAULT. Next MOVE -> done/REJECT.
- enc_err asserted during MOVE on the same cycle position hits the target -> done/ENC_ERR (not OK). CLRERR -> dec_clear pulse, done/OK, cmd_ready in IDLE.
- Simultaneous enc_inc and enc_dec -> position unchanged. Position 0x7FFF plus enc_inc -> 0x8000. Assert reset_n low mid-MOVE -> motor_en=0 and position=0 immediately.
